simon_game_ctrl: RTL

//  Moore/Mealy FSM that sequences the Simon datapath (pattern memory, count/index registers).
//  It drives the datapath's clear/count/write/level/read strobes from its status flags
//  (index_lt_count, input_eq_pattern, is_legal) and the player "next" button.
//  It also exposes game mode and win state on LEDs. One instance sits beside the datapath in the top level.

---
 rtl/simon_game_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/simon_game_ctrl.sv
// Simon game controller: walks the pattern datapath through input, playback, repeat and done phases.
// Strobes are decoded from state and flags each cycle; mode_leds and game_won follow the state register.
module simon_game_ctrl #(
  parameter int MAX_LEN    = 64,
  parameter int PLAY_TICKS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       next,
  input  logic       index_lt_count,
  input  logic       input_eq_pattern,
  input  logic       is_legal,
  output logic       cnt_count,
  output logic       clr_count,
  output logic       cnt_index,
  output logic       clr_index,
  output logic       w_en,
  output logic       set_level,
  output logic       read_memory,
  output logic [2:0] mode_leds,
  output logic       game_won
);

  // Encodings double as the LED pattern shown for each phase.
  typedef enum logic [2:0] {
    S_INPUT    = 3'b001,
    S_PLAYBACK = 3'b010,
    S_REPEAT   = 3'b100,
    S_DONE     = 3'b111
  } state_t;

  localparam logic [6:0]  ROUNDS_MAX = 7'(MAX_LEN);
  localparam logic [23:0] TICK_LAST  = 24'(PLAY_TICKS - 1);
  localparam bit          TIMED      = (PLAY_TICKS != 0);

  state_t      state;
  logic        next_q;
  logic [6:0]  rounds;
  logic [23:0] timer;
  logic        won;

  logic next_pulse;
  logic at_max;
  logic tick_hit;

  assign next_pulse = next & ~next_q;
  assign at_max     = (rounds == ROUNDS_MAX);
  assign tick_hit   = TIMED && (timer == TICK_LAST);

  always_comb begin
    cnt_count   = 1'b0;
    clr_count   = 1'b0;
    cnt_index   = 1'b0;
    clr_index   = 1'b0;
    w_en        = 1'b0;
    set_level   = 1'b0;
    read_memory = 1'b0;
    mode_leds   = 3'b001;
    game_won    = 1'b0;
    if (rst) begin
      clr_count = 1'b1;
      clr_index = 1'b1;
      set_level = 1'b1;
    end else begin
      case (state)
        S_INPUT: begin
          if (at_max) begin
            clr_index = 1'b1;
          end else if (next_pulse && is_legal) begin
            w_en      = 1'b1;
            cnt_count = 1'b1;
            clr_index = 1'b1;
          end
        end
        S_PLAYBACK: begin
          mode_leds   = 3'b010;
          read_memory = index_lt_count;
          if (!index_lt_count)
            clr_index = 1'b1;
          else if (next_pulse || tick_hit)
            cnt_index = 1'b1;
        end
        S_REPEAT: begin
          mode_leds = 3'b100;
          if (!index_lt_count) begin
            clr_index = 1'b1;
          end else if (next_pulse && is_legal) begin
            if (input_eq_pattern)
              cnt_index = 1'b1;
            else
              clr_index = 1'b1;
          end
        end
        S_DONE: begin
          mode_leds   = 3'b111;
          game_won    = won;
          read_memory = index_lt_count;
          if (!index_lt_count)
            clr_index = 1'b1;
          else if (next_pulse)
            cnt_index = 1'b1;
        end
        default: begin
          // Corrupted state: behave like reset for one cycle.
          clr_count = 1'b1;
          clr_index = 1'b1;
          set_level = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_INPUT;
      next_q <= 1'b1;
      rounds <= '0;
      timer  <= '0;
      won    <= 1'b0;
    end else begin
      next_q <= next;
      case (state)
        S_INPUT: begin
          if (at_max) begin
            won   <= 1'b1;
            state <= S_DONE;
          end else if (next_pulse && is_legal) begin
            rounds <= rounds + 7'd1;
            state  <= S_PLAYBACK;
          end
        end
        S_PLAYBACK: begin
          if (!index_lt_count) begin
            timer <= '0;
            state <= S_REPEAT;
          end else if (next_pulse || tick_hit) begin
            timer <= '0;
          end else if (TIMED) begin
            timer <= timer + 24'd1;
          end
        end
        S_REPEAT: begin
          if (!index_lt_count)
            state <= S_INPUT;
          else if (next_pulse && is_legal && !input_eq_pattern)
            state <= S_DONE;
        end
        S_DONE: begin
        end
        default: begin
          state  <= S_INPUT;
          rounds <= '0;
          timer  <= '0;
          won    <= 1'b0;
        end
      endcase
    end
  end

endmodule
